// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and byte constants for the PS/2 key decoder
package ps2_pkg;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef logic [8:0] keycode_t;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: synchronises PS/2 lines, deframes 11-bit frames with parity/stop checks and a stall watchdog
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       code_valid,
  output logic [7:0] code_data,
  output logic       frame_err
);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [2:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  rx_state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, data_q, data_d;
  logic par_q, par_d, valid_q, valid_d, err_q, err_d;
  logic [WW-1:0] wd_q, wd_d;
  logic fall, din;
  // bit 2 is the previous synchronised clock sample
  assign fall = clk_sync_q[2] & ~clk_sync_q[1];
  assign din = dat_sync_q[1];
  assign code_valid = valid_q;
  assign code_data = data_q;
  assign frame_err = err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      state_q <= RX_IDLE;
      cnt_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      wd_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      data_q <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      state_q <= state_d;
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      par_q <= par_d;
      wd_q <= wd_d;
      valid_q <= valid_d;
      err_q <= err_d;
      data_q <= data_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    shift_d = shift_q;
    par_d = par_q;
    valid_d = 1'b0;
    err_d = 1'b0;
    data_d = data_q;
    if (fall) begin
      case (state_q)
        RX_IDLE: begin
          state_d = din ? RX_IDLE : RX_DATA;
          cnt_d = '0;
        end
        RX_DATA: begin
          shift_d = {din, shift_q[7:1]};
          cnt_d = cnt_q + 3'd1;
          state_d = (cnt_q == 3'd7) ? RX_PARITY : RX_DATA;
        end
        RX_PARITY: begin
          par_d = din;
          state_d = RX_STOP;
        end
        default: begin
          valid_d = (^{shift_q, par_q}) & din;
          err_d = ~valid_d;
          data_d = valid_d ? shift_q : data_q;
          state_d = RX_IDLE;
        end
      endcase
    end else if (state_q != RX_IDLE && wd_q == WW'(TIMEOUT_CYCLES)) begin
      err_d = 1'b1;
      state_d = RX_IDLE;
    end
    wd_d = (state_d == RX_IDLE || fall) ? '0 : wd_q + 1'b1;
  end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns PS/2 make/break sequences into per-key held levels and press pulses with auto-repeat
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int NUM_KEYS = 6,
  parameter keycode_t [0:NUM_KEYS-1] KEY_CODES = {9'h16B, 9'h174, 9'h172, 9'h175, 9'h029, 9'h01A},
  parameter logic [NUM_KEYS-1:0] REPEAT_MASK = 6'b000111,
  parameter int DAS_CYCLES = 17_000_000,
  parameter int ARR_CYCLES = 5_000_000,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic                code_valid,
  output logic [7:0]          code_data,
  output logic                frame_err
);
  localparam int RMAX = DAS_CYCLES > ARR_CYCLES ? DAS_CYCLES : ARR_CYCLES;
  localparam int RW = $clog2(RMAX + 1);
  logic ext_q, ext_d, brk_q, brk_d, is_key;
  ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .code_valid(code_valid),
    .code_data(code_data),
    .frame_err(frame_err)
  );
  assign is_key = code_valid && code_data != PS2_EXT && code_data != PS2_BRK && code_data != PS2_PAUSE;
  always_comb begin
    ext_d = frame_err ? 1'b0 : !code_valid ? ext_q : code_data == PS2_EXT ? 1'b1 : code_data == PS2_BRK ? ext_q : 1'b0;
    brk_d = frame_err ? 1'b0 : !code_valid ? brk_q : code_data == PS2_BRK ? 1'b1 : code_data == PS2_EXT ? brk_q : 1'b0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else begin
      ext_q <= ext_d;
      brk_q <= brk_d;
    end
  end
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic held_q, held_d, press_q, press_d, hit;
    logic [RW-1:0] rcnt_q, rcnt_d;
    assign hit = is_key && {ext_q, code_data} == KEY_CODES[k];
    assign key_held[k] = held_q;
    assign key_press[k] = press_q;
    // a break beats a repeat expiry in the same cycle
    always_comb begin
      held_d = held_q;
      press_d = 1'b0;
      rcnt_d = rcnt_q;
      if (hit && brk_q) begin
        held_d = 1'b0;
        rcnt_d = '0;
      end else if (hit && !held_q) begin
        held_d = 1'b1;
        press_d = 1'b1;
        rcnt_d = RW'(DAS_CYCLES);
      end else if (REPEAT_MASK[k] && held_q) begin
        press_d = rcnt_q == RW'(1);
        rcnt_d = press_d ? RW'(ARR_CYCLES) : rcnt_q - 1'b1;
      end
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        held_q <= 1'b0;
        press_q <= 1'b0;
        rcnt_q <= '0;
      end else begin
        held_q <= held_d;
        press_q <= press_d;
        rcnt_q <= rcnt_d;
      end
    end
  end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: drives PS/2 frames and checks all outputs each cycle against an event-level model
module tb_ps2_key_decoder;
  localparam int DAS = 20, ARR = 5, TMO = 100, H = 15;
  localparam logic [8:0] KC [6] = '{9'h16B, 9'h174, 9'h172, 9'h175, 9'h029, 9'h01A};
  localparam logic [5:0] MASK = 6'b000111;
  logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [5:0] key_held, key_press;
  logic code_valid, frame_err;
  logic [7:0] code_data;
  ps2_key_decoder #(.DAS_CYCLES(DAS), .ARR_CYCLES(ARR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .key_held(key_held),
    .key_press(key_press),
    .code_valid(code_valid),
    .code_data(code_data),
    .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  typedef struct {int c; bit err; logic [7:0] b;} ev_t;
  ev_t evq[$];
  ev_t ev;
  int cyc = 0, checks = 0, errors = 0, last_fall = 0, ev_cyc = 0, ferr_cnt = 0, tmp = 0;
  int press_cnt[6];
  int mk[6];
  logic [5:0] m_held, m_press;
  logic m_valid, m_err, m_ext, m_brk, pend_v;
  logic [7:0] m_data, pend_b;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  // model: frame results arrive on a schedule; key effects follow a cycle later
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_held = '0; m_press = '0; m_valid = 1'b0; m_err = 1'b0; m_data = '0;
      m_ext = 1'b0; m_brk = 1'b0; pend_v = 1'b0; pend_b = '0;
      evq.delete();
    end else begin
      m_press = '0;
      if (pend_v) begin
        if (pend_b == 8'hE0) m_ext = 1'b1;
        else if (pend_b == 8'hF0) m_brk = 1'b1;
        else begin
          if (pend_b != 8'hE1)
            for (int k = 0; k < 6; k++)
              if ({m_ext, pend_b} == KC[k]) begin
                if (m_brk) m_held[k] = 1'b0;
                else if (!m_held[k]) begin
                  m_held[k] = 1'b1; m_press[k] = 1'b1; mk[k] = cyc;
                end
              end
          m_ext = 1'b0; m_brk = 1'b0;
        end
      end
      for (int k = 0; k < 6; k++)
        if (MASK[k] && m_held[k] && cyc - mk[k] >= DAS && (cyc - mk[k] - DAS) % ARR == 0) m_press[k] = 1'b1;
      pend_v = 1'b0; m_valid = 1'b0; m_err = 1'b0;
      if (evq.size() > 0 && evq[0].c == cyc) begin
        ev = evq.pop_front();
        if (ev.err) begin
          m_err = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
        end else begin
          m_valid = 1'b1; m_data = ev.b; pend_v = 1'b1; pend_b = ev.b;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      chk("held_in_rst", key_held, 0);
      chk("press_in_rst", key_press, 0);
      chk("valid_in_rst", code_valid, 0);
      chk("data_in_rst", code_data, 0);
      chk("err_in_rst", frame_err, 0);
    end else begin
      chk("key_held", key_held, m_held);
      chk("key_press", key_press, m_press);
      chk("code_valid", code_valid, m_valid);
      chk("code_data", code_data, m_data);
      chk("frame_err", frame_err, m_err);
    end
    for (int k = 0; k < 6; k++) press_cnt[k] += int'(key_press[k]);
    ferr_cnt += int'(frame_err);
  end
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic ps2_bit(input logic v);
    ps2_data = v;
    wait_cyc(H);
    ps2_clk = 1'b0;
    last_fall = cyc;
    wait_cyc(H);
    ps2_clk = 1'b1;
  endtask
  task automatic send(input logic [7:0] b, input bit flip);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b ^ flip);
    ps2_data = 1'b1;
    wait_cyc(H);
    ps2_clk = 1'b0;
    ev_cyc = cyc + 3;
    evq.push_back('{c: ev_cyc, err: flip, b: b});
    wait_cyc(H);
    ps2_clk = 1'b1;
  endtask
  task automatic partial(input logic [7:0] b, input int n);
    ps2_bit(1'b0);
    for (int i = 0; i < n; i++) ps2_bit(b[i]);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
  initial begin
    wait_cyc(4);
    rst = 1'b0;
    wait_cyc(3);
    chk("reset_held", key_held, 0);
    chk("reset_data", code_data, 0);
    send(8'h1C, 1'b0);
    chk("lit_data_1c", code_data, 8'h1C);
    chk("lit_held_1c", key_held, 0);
    send(8'hE0, 1'b0);
    press_cnt[0] = 0;
    send(8'h6B, 1'b0);
    while (cyc < ev_cyc + 40) wait_cyc(1);
    chk("lit_left_held", key_held, 6'b000001);
    chk("lit_left_pulses_40", press_cnt[0], 5);
    send(8'hE0, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h6B, 1'b0);
    chk("lit_left_released", key_held, 0);
    tmp = press_cnt[0];
    wait_cyc(60);
    chk("lit_left_quiet", press_cnt[0] - tmp, 0);
    send(8'h74, 1'b0);
    chk("lit_ext_cleared", key_held, 0);
    ferr_cnt = 0;
    send(8'h29, 1'b1);
    chk("lit_parity_err", ferr_cnt, 1);
    chk("lit_parity_held", key_held, 0);
    press_cnt[4] = 0;
    send(8'h29, 1'b0);
    chk("lit_space_held", key_held, 6'b010000);
    send(8'hF0, 1'b0);
    send(8'h29, 1'b0);
    chk("lit_space_pulses", press_cnt[4], 1);
    chk("lit_space_released", key_held, 0);
    ferr_cnt = 0;
    partial(8'h55, 4);
    evq.push_back('{c: last_fall + TMO + 4, err: 1'b1, b: 8'h00});
    wait_cyc(TMO + 10);
    chk("lit_timeout_errs", ferr_cnt, 1);
    send(8'h1A, 1'b0);
    chk("lit_z_held", key_held, 6'b100000);
    send(8'hF0, 1'b0);
    send(8'h1A, 1'b0);
    send(8'hE0, 1'b0);
    send(8'h72, 1'b0);
    chk("lit_down_held", key_held, 6'b000100);
    partial(8'h1A, 3);
    ps2_data = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("lit_async_held", key_held, 0);
    chk("lit_async_press", key_press, 0);
    chk("lit_async_valid", code_valid, 0);
    chk("lit_async_data", code_data, 0);
    chk("lit_async_err", frame_err, 0);
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(3);
    send(8'h1A, 1'b0);
    chk("lit_post_rst_held", key_held, 6'b100000);
    chk("lit_post_rst_data", code_data, 8'h1A);
    wait_cyc(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
